cia_sp_peer: RTL and testbench

Serial-port partner for the 6526 CIA shift register: the device at the far end of the CIA's SP/CNT pins. When the CIA shifts out, this block receives bytes by sampling SP on rising CNT edges. When the CIA is in input mode, this block transmits bytes by generating CNT clock pulses and SP data. It runs on the system clock with a phi2 enable strobe and presents a simple valid/ready byte interface to the host logic on its side.

---
 rtl/cia_sp_peer_if.sv | 21 ++
 rtl/cia_sp_peer.sv | 121 ++++++++++++
 tb/tb_cia_sp_peer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cia_sp_peer_if.sv
// Host-side byte interface of the CIA serial-port peer.
interface cia_sp_peer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;

  // Host logic drives bytes in and consumes received bytes
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, rx_data, rx_valid
  );

  // Peer block accepts bytes and reports received bytes
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, rx_data, rx_valid
  );
endinterface

// File: rtl/cia_sp_peer.sv
// Far-end partner for the 6526 CIA shift register: receives on rising CNT,
// transmits by generating CNT pulses with SP changing only on falling CNT.
module cia_sp_peer #(
  parameter int unsigned CNT_HALF = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         phi2,
  cia_sp_peer_if.slave host,
  input  logic         cnt_in,
  input  logic         sp_in,
  output logic         cnt_out,
  output logic         sp_out
);

  localparam int unsigned HALF_W = 8;
  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(CNT_HALF - 1);

  typedef enum logic [1:0] {IDLE, ARM, LOW, HIGH} state_t;

  state_t            state;
  logic [7:0]        tx_shift;
  logic [7:0]        rx_shift;
  logic [HALF_W-1:0] half_cnt;
  logic [2:0]        bit_cnt;
  logic [2:0]        rx_cnt;
  logic              cnt_prev;
  logic              accept_c;
  logic              rise_c;

  assign accept_c = host.tx_valid & host.tx_ready;
  assign rise_c   = cnt_in & ~cnt_prev;

  // Transmit FSM plus receive shifter; edges on our own CNT are ignored outside IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tx_shift      <= 8'h00;
      rx_shift      <= 8'h00;
      half_cnt      <= '0;
      bit_cnt       <= 3'd0;
      rx_cnt        <= 3'd0;
      cnt_prev      <= 1'b1;
      cnt_out       <= 1'b1;
      sp_out        <= 1'b1;
      host.tx_ready <= 1'b1;
      host.tx_done  <= 1'b0;
      host.rx_data  <= 8'h00;
      host.rx_valid <= 1'b0;
    end else begin
      host.tx_done  <= 1'b0;
      host.rx_valid <= 1'b0;

      if (phi2) begin
        cnt_prev <= cnt_in;
        if (rise_c && (state == IDLE)) begin
          rx_shift <= {rx_shift[6:0], sp_in};
          rx_cnt   <= rx_cnt + 3'd1;
          if (rx_cnt == 3'd7) begin
            host.rx_data  <= {rx_shift[6:0], sp_in};
            host.rx_valid <= 1'b1;
          end
        end
      end

      case (state)
        IDLE: begin
          if (accept_c) begin
            tx_shift      <= host.tx_data;
            bit_cnt       <= 3'd0;
            rx_cnt        <= 3'd0;
            host.tx_ready <= 1'b0;
            state         <= ARM;
          end
        end
        ARM: begin
          if (phi2) begin
            cnt_out  <= 1'b0;
            sp_out   <= tx_shift[7];
            half_cnt <= HALF_LOAD;
            state    <= LOW;
          end
        end
        LOW: begin
          if (phi2) begin
            if (half_cnt == '0) begin
              cnt_out  <= 1'b1;
              half_cnt <= HALF_LOAD;
              tx_shift <= {tx_shift[6:0], 1'b0};
              state    <= HIGH;
            end else begin
              half_cnt <= half_cnt - HALF_W'(1);
            end
          end
        end
        HIGH: begin
          if (phi2) begin
            if (half_cnt == '0) begin
              if (bit_cnt == 3'd7) begin
                sp_out        <= 1'b1;
                host.tx_ready <= 1'b1;
                host.tx_done  <= 1'b1;
                state         <= IDLE;
              end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                cnt_out  <= 1'b0;
                sp_out   <= tx_shift[7];
                half_cnt <= HALF_LOAD;
                state    <= LOW;
              end
            end else begin
              half_cnt <= half_cnt - HALF_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cia_sp_peer.sv
// Scoreboard bench for cia_sp_peer: TX bytes are reassembled from SP at CNT
// rises and RX bytes are driven as a CIA would, both checked against queues.
module tb_cia_sp_peer;

  localparam int HALF = 2;

  logic clk;
  logic reset;
  logic phi2;
  logic cia_cnt;
  logic sp_in;
  wire  cnt_in;
  logic cnt_out;
  logic sp_out;

  cia_sp_peer_if host_if ();

  cia_sp_peer #(.CNT_HALF(HALF)) dut (
    .clk     (clk),
    .reset   (reset),
    .phi2    (phi2),
    .host    (host_if),
    .cnt_in  (cnt_in),
    .sp_in   (sp_in),
    .cnt_out (cnt_out),
    .sp_out  (sp_out)
  );

  // CNT is wired-AND of the CIA drive and ours
  assign cnt_in = cia_cnt & cnt_out;

  int n_cmp = 0;
  int n_err = 0;
  int ticks = 0;
  int done_cnt = 0;
  int nbits = 0;
  logic [7:0] obs = 8'h00;
  bit gap_chk = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // phi2 strobe every 4th clk
  initial begin
    int pc;
    pc = 0;
    phi2 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pc = (pc + 1) % 4;
      phi2 = (pc == 0);
    end
  end

  // Line and host monitor; at a negedge phi2 still holds the value of the last posedge
  initial begin
    logic prev_cnt;
    bit   in_byte;
    int   fall_t, rise_t, start_t;
    logic [7:0] e;
    prev_cnt = 1'b1;
    in_byte = 0;
    fall_t = 0; rise_t = 0; start_t = 0;
    forever begin
      @(negedge clk);
      if (phi2) ticks++;
      if (reset) begin
        prev_cnt = cnt_out;
        in_byte = 0;
        nbits = 0;
        obs = 8'h00;
        continue;
      end
      if (prev_cnt === 1'b1 && cnt_out === 1'b0) begin
        if (!in_byte) begin
          in_byte = 1;
          start_t = ticks;
          if (gap_chk) begin
            check_eq("b2b_gap", 32'(ticks - rise_t), 32'(HALF + 1));
            gap_chk = 0;
          end
        end else begin
          check_eq("high_len", 32'(ticks - rise_t), 32'(HALF));
        end
        fall_t = ticks;
      end
      if (prev_cnt === 1'b0 && cnt_out === 1'b1) begin
        check_eq("low_len", 32'(ticks - fall_t), 32'(HALF));
        obs = {obs[6:0], sp_out};
        nbits++;
        rise_t = ticks;
      end
      if (host_if.tx_done === 1'b1) begin
        done_cnt++;
        check_eq("done_len", 32'(ticks - start_t), 32'(16 * HALF));
        check_eq("done_sp", 32'(sp_out), 1);
        check_eq("done_nbits", 32'(nbits), 8);
        if (tx_q.size() == 0) begin
          check_eq("tx_unexp", 32'(tx_q.size()), 1);
        end else begin
          e = tx_q.pop_front();
          check_eq("tx_byte", 32'(obs), 32'(e));
        end
        in_byte = 0;
        nbits = 0;
      end
      if (host_if.rx_valid === 1'b1) begin
        if (rx_q.size() == 0) begin
          check_eq("rx_unexp", 32'(rx_q.size()), 1);
        end else begin
          e = rx_q.pop_front();
          check_eq("rx_byte", 32'(host_if.rx_data), 32'(e));
        end
      end
      prev_cnt = cnt_out;
    end
  end

  task automatic wait_phi2(input int n);
    repeat (n) begin
      do @(posedge clk); while (!phi2);
    end
  endtask

  // Single byte: valid for one accept clk, data scrambled afterwards
  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (host_if.tx_ready !== 1'b1 && k < 2000);
    check_eq("rdy_pre", 32'(host_if.tx_ready), 1);
    @(posedge clk); #1;
    host_if.tx_data = b;
    host_if.tx_valid = 1'b1;
    tx_q.push_back(b);
    @(posedge clk); #1;
    host_if.tx_valid = 1'b0;
    host_if.tx_data = ~b;
    @(negedge clk);
    check_eq("rdy_drop", 32'(host_if.tx_ready), 0);
  endtask

  task automatic wait_done();
    int d0, k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", 32'(done_cnt - d0), 1);
  endtask

  // CIA-side shift-out of n bits, MSB of the n-bit field first
  task automatic rx_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cia_cnt = 1'b0;
      sp_in = b[n-1-i];
      wait_phi2(2);
      @(posedge clk); #1;
      cia_cnt = 1'b1;
      if (i == 7) begin
        do @(posedge clk); while (!phi2);
        @(negedge clk);
        check_eq("rxv_time", 32'(host_if.rx_valid), 1);
        @(negedge clk);
        check_eq("rxv_pulse", 32'(host_if.rx_valid), 0);
      end else begin
        wait_phi2(2);
      end
    end
    if (n == 8) wait_phi2(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, k;
    reset = 1'b1;
    cia_cnt = 1'b1;
    sp_in = 1'b1;
    host_if.tx_data = 8'h00;
    host_if.tx_valid = 1'b0;

    // Reset with CNT toggling
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cia_cnt = ~cia_cnt;
      @(negedge clk);
      check_eq("rst_rxv", 32'(host_if.rx_valid), 0);
    end
    @(posedge clk); #1;
    cia_cnt = 1'b1;
    @(negedge clk);
    check_eq("rst_cnt", 32'(cnt_out), 1);
    check_eq("rst_sp", 32'(sp_out), 1);
    check_eq("rst_rdy", 32'(host_if.tx_ready), 1);
    check_eq("rst_done", 32'(host_if.tx_done), 0);
    check_eq("rst_rxd", 32'(host_if.rx_data), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_phi2(2);

    // Single TX byte
    send(8'hA5);
    wait_done();
    @(negedge clk);
    check_eq("tx_sp_idle", 32'(sp_out), 1);
    check_eq("tx_done_once", 32'(host_if.tx_done), 0);

    // Single RX byte
    rx_q.push_back(8'h3C);
    rx_bits(8'h3C, 8);
    check_eq("rx_hold", 32'(host_if.rx_data), 32'h3C);

    // Back-to-back TX with tx_valid held
    @(posedge clk); #1;
    host_if.tx_data = 8'h01;
    host_if.tx_valid = 1'b1;
    tx_q.push_back(8'h01);
    tx_q.push_back(8'hFF);
    @(posedge clk); #1;
    host_if.tx_data = 8'hFF;
    @(negedge clk);
    check_eq("b2b_busy", 32'(host_if.tx_ready), 0);
    k = 0;
    while (host_if.tx_done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("b2b_rdy", 32'(host_if.tx_ready), 1);
    gap_chk = 1;
    @(posedge clk); #1;
    host_if.tx_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_acc", 32'(host_if.tx_ready), 0);
    wait_done();

    // Partial RX, then TX, then a full RX byte
    rx_bits(8'h07, 3);
    send(8'h80);
    wait_done();
    rx_q.push_back(8'h5A);
    rx_bits(8'h5A, 8);

    // Reset during bit 4 of a TX
    send(8'hC3);
    k = 0;
    while (!(nbits == 4 && cnt_out === 1'b0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("mid_bit4", 32'(nbits), 4);
    d0 = done_cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    tx_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_cnt", 32'(cnt_out), 1);
    check_eq("mid_sp", 32'(sp_out), 1);
    check_eq("mid_rdy", 32'(host_if.tx_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_phi2(4);
    check_eq("mid_nodone", 32'(done_cnt), 32'(d0));
    send(8'h0F);
    wait_done();

    wait_phi2(2);
    check_eq("txq_empty", 32'(tx_q.size()), 0);
    check_eq("rxq_empty", 32'(rx_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
